hex_display_ctrl: RTL and testbench
===================================

// Module: hex_display_ctrl
// PURPOSE
//  Multi-digit hex seven-segment display controller for the DE2-115 HEX bank.
//  - Accepts a NUM_DIGITS-wide hex word over a valid/ready handshake.
//  - Decodes digits serially, one per clock, through one shared decoder.
//  - Commits all digits to the segment outputs atomically.
//  - Adds leading-zero blanking and per-digit blinking.
// PARAMETERS
//  NUM_DIGITS  8           number of hex digits (1..16)
//  CLK_HZ      50_000_000  clk frequency in Hz
//  BLINK_HZ    2           blink frequency in Hz; half-period HALF = CLK_HZ/(2*BLINK_HZ) cycles
//  ACTIVE_LOW  1           1: segment on = 0 (DE2-115); 0: outputs inverted
// PORTS
//  clk         in   1              system clock
//  rst_n       in   1              asynchronous active-low reset
//  in_valid    in   1              in_data/blank_lz valid
//  in_ready    out  1              controller idle, can accept
//  in_data     in   4*NUM_DIGITS   hex word; digit i = in_data[4i+3:4i], digit 0 rightmost
//  blank_lz    in   1              leading-zero blanking request, sampled with in_data
//  blink_mask  in   NUM_DIGITS     1 = digit blinks (live, not sampled)
//  seg_out     out  7*NUM_DIGITS   digit i = seg_out[7i+6:7i], bit6=g .. bit0=a
// BEHAVIOUR
//  - Reset: all seg_out digits blank (7'h7F if ACTIVE_LOW, else 7'h00); in_ready=1;
//    FSM=IDLE; blink counter=0; blink phase=visible.
//  - Encodings (ACTIVE_LOW=1):
//    0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//    ACTIVE_LOW=0 outputs the bitwise inverse.
//  - FSM:
//    IDLE: in_ready=1. On in_valid&in_ready (edge E0), latch in_data and blank_lz,
//      set idx=NUM_DIGITS-1, clear nz_seen, go to DECODE.
//    DECODE: in_ready=0. Each edge decodes digit idx (MS first) into a shadow buffer.
//      Set nz_seen when the digit is nonzero. If blank_lz&!nz_seen&digit==0&idx!=0,
//      store blank. Digit 0 is never LZ-blanked.
//      At idx==0 go to COMMIT; otherwise idx--.
//    COMMIT: shadow buffer -> display register in one edge, then go to IDLE.
//  - Timing: first decode on E1, last on E_N, commit on E_N+1. seg_out shows the new word
//    after E_N+1, and in_ready=1 in the same cycle. Total latency NUM_DIGITS+1 clocks.
//  - in_valid while in_ready=0 is ignored; the word is not queued.
//    Zero-cycle back-to-back accept is not supported.
//  - Display register holds its value indefinitely between commits. seg_out never shows a
//    partially decoded word.
//  - Reset mid-DECODE aborts the transfer; the display returns to blank.
//  - Input width rules: in_data is zero-extended per digit; idx is $clog2(NUM_DIGITS) bits
//    and never wraps below 0.
// CONFIGURATION
//  HEX_DISPLAY_BLINK_EN defined:
//   - Free-running counter 0..HALF-1. Blink phase toggles on wrap.
//   - While phase=hidden, digits with blink_mask[i]=1 output blank.
//   - Blanking is applied combinationally after the display register.
//   - Blink phase is unaffected by transfers.
//  HEX_DISPLAY_BLINK_EN undefined:
//   - No counter logic; blink_mask is ignored.
//   - seg_out = display register.
// STRUCTURE
//  Package hex_display_pkg:
//   - 16-entry segment constant table (active-low form)
//   - SEG_BLANK constant
//   - FSM state typedef {IDLE, DECODE, COMMIT}
//  Sub-module hex_seg_lut:
//   - Combinational 4-bit -> 7-bit decoder.
//   - Single instance, shared across all digits.
// TESTING
//  1. Reset, send 32'h0123_4567, blank_lz=0:
//     digits 7..0 = 40,79,24,30,19,12,02,78; valid 9 clocks after accept.
//  2. Send 32'h89AB_CDEF: digits = 00,10,08,03,46,21,06,0E.
//     in_ready low for exactly 9 cycles; seg_out unchanged until commit.
//  3. blank_lz=1:
//     - 32'h0000_0A05: digits 7..3 = 7F; digit2 = 08, digit1 = 40, digit0 = 12.
//     - 32'h0: only digit0 = 40.
//  4. Pulse in_valid during DECODE with another word: ignored; first word displayed.
//     Then assert rst_n=0 mid-DECODE: all digits 7F, in_ready=1.
//  5. HEX_DISPLAY_BLINK_EN, CLK_HZ=100, BLINK_HZ=5, blink_mask=8'h01:
//     digit0 alternates value / 7F every 10 clocks; other digits steady.
//  6. ACTIVE_LOW=0, NUM_DIGITS=4, send 16'h1F08: digits = 06,71,3F,7F.

Source files
------------

// File: rtl/hex_display_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_pkg
//   Shared definitions for the hex seven-segment display controller:
//   - SEG_TABLE : 16-entry hex -> segment table, active-low form
//                 (bit6=g .. bit0=a, segment lit = 0)
//   - SEG_BLANK : all segments off, active-low form
//   - state_e   : controller FSM states
// -----------------------------------------------------------------------------
package hex_display_pkg;

   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      COMMIT
   } state_e;

endpackage

// File: rtl/hex_display_ctrl_lut.sv
// -----------------------------------------------------------------------------
// hex_seg_lut
//   Combinational 4-bit hex digit to 7-bit segment decoder (active-low form).
//   A single instance is shared by all digit positions of the controller.
// Ports:
//   digit_i  in   4   hex digit
//   seg_o    out  7   segment pattern, bit6=g .. bit0=a, lit = 0
// -----------------------------------------------------------------------------
module hex_seg_lut
   import hex_display_pkg::*;
(
   input  logic [3:0]       digit_i,
   output logic [SEG_W-1:0] seg_o
);

   assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// hex_display_ctrl
//   Multi-digit hex seven-segment display controller. A hex word is accepted
//   over a valid/ready handshake, decoded one digit per clock (most significant
//   first) through one shared decoder into a shadow buffer, then committed to
//   the display register in a single edge so the outputs never show a
//   partially decoded word. Optional leading-zero blanking per word.
//
//   Optional feature macro: HEX_DISPLAY_BLINK_EN
//     defined   : free-running half-period counter toggles a blink phase;
//                 digits selected by blink_mask are blanked while hidden.
//     undefined : no blink logic, blink_mask ignored.
//
// Ports:
//   clk         in   1              system clock
//   rst_n       in   1              asynchronous active-low reset
//   in_valid    in   1              in_data/blank_lz valid
//   in_ready    out  1              controller idle, can accept
//   in_data     in   4*NUM_DIGITS   hex word, digit 0 rightmost
//   blank_lz    in   1              leading-zero blanking, sampled with in_data
//   blink_mask  in   NUM_DIGITS     1 = digit blinks (live)
//   seg_out     out  7*NUM_DIGITS   digit i = seg_out[7i+6:7i], bit6=g..bit0=a
// -----------------------------------------------------------------------------
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_HZ     = 50_000_000,
   parameter int BLINK_HZ   = 2,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [4*NUM_DIGITS-1:0]     in_data,
   input  logic                        blank_lz,
   input  logic [NUM_DIGITS-1:0]       blink_mask,
   output logic [SEG_W*NUM_DIGITS-1:0] seg_out
);

   localparam int               IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_MS = IDX_W'(NUM_DIGITS - 1);
   localparam int               DISP_W = SEG_W * NUM_DIGITS;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] word_q, word_d;
   logic                    blz_q, blz_d;
   logic                    nz_q, nz_d;
   logic [DISP_W-1:0]       shadow_q, shadow_d;
   logic [DISP_W-1:0]       disp_q, disp_d;

   logic [3:0]              cur_digit;
   logic [SEG_W-1:0]        cur_seg;
   logic [DISP_W-1:0]       seg_al;

   assign cur_digit = word_q[idx_q*4 +: 4];

   hex_seg_lut u_lut (
      .digit_i (cur_digit),
      .seg_o   (cur_seg)
   );

   assign in_ready = (state_q == IDLE);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      word_d   = word_q;
      blz_d    = blz_q;
      nz_d     = nz_q;
      shadow_d = shadow_q;
      disp_d   = disp_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d  = in_data;
               blz_d   = blank_lz;
               idx_d   = IDX_MS;
               nz_d    = 1'b0;
               state_d = DECODE;
            end
         end
         DECODE: begin
            nz_d = nz_q | (cur_digit != 4'h0);
            // A zero is only blanked while no nonzero digit has been seen to its
            // left; the rightmost digit always shows so a zero word reads "0".
            if (blz_q && !nz_q && (cur_digit == 4'h0) && (idx_q != '0))
               shadow_d[idx_q*SEG_W +: SEG_W] = SEG_BLANK;
            else
               shadow_d[idx_q*SEG_W +: SEG_W] = cur_seg;
            if (idx_q == '0)
               state_d = COMMIT;
            else
               idx_d = idx_q - 1'b1;
         end
         COMMIT: begin
            disp_d  = shadow_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         word_q   <= '0;
         blz_q    <= 1'b0;
         nz_q     <= 1'b0;
         shadow_q <= {NUM_DIGITS{SEG_BLANK}};
         disp_q   <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         word_q   <= word_d;
         blz_q    <= blz_d;
         nz_q     <= nz_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
      end
   end

`ifdef HEX_DISPLAY_BLINK_EN
   localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;   // 1 = hidden

   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
      if (cnt_q == CNT_W'(HALF - 1)) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // Blanking sits after the display register so blinking never disturbs
   // the committed word and is independent of transfers.
   always_comb begin
      seg_al = disp_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (phase_q && blink_mask[i])
            seg_al[i*SEG_W +: SEG_W] = SEG_BLANK;
      end
   end
`else
   localparam int unused_half = CLK_HZ / (2 * BLINK_HZ);
   logic unused_blink;

   assign unused_blink = ^{blink_mask, unused_half[0]};
   assign seg_al       = disp_q;
`endif

   assign seg_out = ACTIVE_LOW ? seg_al : ~seg_al;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        blank_lz;
   logic [7:0]  blink_mask;
   logic [55:0] seg_out;

   logic        in_valid2;
   logic        in_ready2;
   logic [15:0] in_data2;
   logic        blank_lz2;
   logic [3:0]  blink_mask2;
   logic [27:0] seg_out2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hex_display_ctrl #(
      .NUM_DIGITS (8),
      .CLK_HZ     (100),
      .BLINK_HZ   (5),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .blank_lz   (blank_lz),
      .blink_mask (blink_mask),
      .seg_out    (seg_out)
   );

   hex_display_ctrl #(
      .NUM_DIGITS (4),
      .CLK_HZ     (100),
      .BLINK_HZ   (5),
      .ACTIVE_LOW (1'b0)
   ) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid2),
      .in_ready   (in_ready2),
      .in_data    (in_data2),
      .blank_lz   (blank_lz2),
      .blink_mask (blink_mask2),
      .seg_out    (seg_out2)
   );

   typedef struct {
      logic [31:0] data;
      logic        blz;
      logic [55:0] exp;
   } vec_t;

   vec_t vt [6];

   localparam logic [55:0] ALL_BLANK = {8{7'h7F}};
   localparam logic [55:0] SEG_W1    = {7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79};
   localparam logic [55:0] SEG_0123  = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic accept(input logic [31:0] d, input logic b);
      @(negedge clk);
      in_data  = d;
      blank_lz = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts cycles until in_ready returns, noting whether seg_out stayed at
   // hold_val the whole time. Bounded so a stuck controller still finishes.
   task automatic wait_commit(input logic [55:0] hold_val, output int lat, output bit held);
      int count;
      count = 0;
      held  = 1'b1;
      while (!in_ready && count < 40) begin
         if (seg_out !== hold_val) held = 1'b0;
         @(posedge clk);
         #1;
         count++;
      end
      lat = count;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      bit          held;
      logic [55:0] prev;

      vt[0] = '{32'h0123_4567, 1'b0, SEG_0123};
      vt[1] = '{32'h89AB_CDEF, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
      vt[2] = '{32'h0000_0A05, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12}};
      vt[3] = '{32'h0000_0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
      vt[4] = '{32'h0000_0A05, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h12}};
      vt[5] = '{32'hF000_0001, 1'b1, SEG_W1};

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      blank_lz    = 1'b0;
      blink_mask  = 8'h00;
      in_valid2   = 1'b0;
      in_data2    = '0;
      blank_lz2   = 1'b0;
      blink_mask2 = 4'h0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_seg", {8'h0, seg_out}, {8'h0, ALL_BLANK});
      check("reset_ready", {63'h0, in_ready}, 64'h1);
      check("reset_seg_inv", {36'h0, seg_out2}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_seg", {8'h0, seg_out}, {8'h0, ALL_BLANK});

      // Table-driven words
      for (int i = 0; i < 6; i++) begin
         prev = seg_out;
         accept(vt[i].data, vt[i].blz);
         check($sformatf("busy_%0d", i), {63'h0, in_ready}, 64'h0);
         wait_commit(prev, lat, held);
         check($sformatf("latency_%0d", i), 64'(lat), 64'd9);
         check($sformatf("hold_%0d", i), {63'h0, held}, 64'h1);
         check($sformatf("seg_%0d", i), {8'h0, seg_out}, {8'h0, vt[i].exp});
      end

      // Display holds between commits
      repeat (15) @(posedge clk);
      #1;
      check("hold_idle", {8'h0, seg_out}, {8'h0, SEG_W1});

      // in_valid during DECODE is ignored and not queued
      accept(32'h0123_4567, 1'b0);
      prev = seg_out;
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_data  = 32'h89AB_CDEF;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_commit(prev, lat, held);
      check("ign_hold", {63'h0, held}, 64'h1);
      check("ign_seg", {8'h0, seg_out}, {8'h0, SEG_0123});
      repeat (12) @(posedge clk);
      #1;
      check("ign_noqueue", {8'h0, seg_out}, {8'h0, SEG_0123});
      check("ign_ready", {63'h0, in_ready}, 64'h1);

      // Reset mid-DECODE aborts the transfer and blanks the display
      accept(32'h89AB_CDEF, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_seg", {8'h0, seg_out}, {8'h0, ALL_BLANK});
      check("rst_mid_ready", {63'h0, in_ready}, 64'h1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("rst_abort_seg", {8'h0, seg_out}, {8'h0, ALL_BLANK});
      check("rst_abort_ready", {63'h0, in_ready}, 64'h1);

      // Inverted polarity, 4 digits
      @(negedge clk);
      in_data2  = 16'h1F08;
      in_valid2 = 1'b1;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      lat = 0;
      while (!in_ready2 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("inv_latency", 64'(lat), 64'd5);
      check("inv_seg", {36'h0, seg_out2}, {36'h0, 7'h06, 7'h71, 7'h3F, 7'h7F});

      // Blink behaviour on digit 0 with 01234567 displayed
      accept(32'h0123_4567, 1'b0);
      wait_commit(ALL_BLANK, lat, held);
      check("blink_pre_seg", {8'h0, seg_out}, {8'h0, SEG_0123});
      blink_mask = 8'h01;
`ifdef HEX_DISPLAY_BLINK_EN
      begin
         logic [6:0] s [60];
         bit         upper_ok;
         bit         pat_ok;
         int         t;
         logic [6:0] shown;
         upper_ok = 1'b1;
         for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            s[k] = seg_out[6:0];
            if (seg_out[55:7] !== SEG_0123[55:7]) upper_ok = 1'b0;
         end
         t = 0;
         for (int k = 1; k < 60; k++) begin
            if (t == 0 && s[k] !== s[k-1]) t = k;
         end
         pat_ok = (t != 0) && (t <= 20);
         if (pat_ok) begin
            for (int k = 0; k < 40; k++) begin
               if (s[t+k] !== (((k / 10) % 2 == 0) ? s[t] : s[t-1])) pat_ok = 1'b0;
            end
         end
         shown = (s[t] == 7'h7F) ? s[(t > 0) ? t - 1 : 0] : s[t];
         check("blink_period", {63'h0, pat_ok}, 64'h1);
         check("blink_values", {57'h0, shown}, {57'h0, 7'h78});
         check("blink_others", {63'h0, upper_ok}, 64'h1);
      end
`else
      begin
         bit steady;
         steady = 1'b1;
         for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (seg_out !== SEG_0123) steady = 1'b0;
         end
         check("mask_ignored", {63'h0, steady}, 64'h1);
      end
`endif
      blink_mask = 8'h00;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
